instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 16'h4C00, meaning the bubble instruction; bits [15:13] SHALL NOT be 3'b000 or 3'b001.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk is the single clock and rst is asynchronous, active-high.
REQ-004 SHALL have the following ports, given as name, direction, width and meaning:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous active-high reset.
- stall  in  8  per-register RAW stall from the pipeline controller; any bit set means stall.
- PC_next  in  16  predicted next PC from the pipeline controller, updated on the negedge.
- flush  in  1  execute-stage branch mispredict.
- flush_pc  in  16  restart address (the controller's LBPC).
- imem_req  out  1  instruction memory read request.
- imem_addr  out  16  read address.
- imem_ack  in  1  read data valid; meaningful only while imem_req=1.
- imem_rdata  in  16  instruction word.
- instr_out  out  16  IF/ID instruction register.
- instr_valid  out  1  instr_out holds a real instruction.
- PC_out  out  16  address of instr_out; drives the controller's PC_in.
- three_msb  out  3  instr_out[15:13].
- thirteen_lsb  out  13  instr_out[12:0].
- fetch_err  out  1  sticky memory-timeout flag.
- fetch_count  out  16  number of instructions captured.

Function
REQ-005 SHALL implement the FSM states FETCH, ADVANCE and ERROR.
REQ-006 SHALL drive imem_req = (state==FETCH) & ~|stall & ~flush.
REQ-007 SHALL drive imem_addr = {fetch_addr[15:1],1'b0} combinationally.
REQ-008 SHALL perform a capture in FETCH when imem_req & imem_ack: instr_out<=imem_rdata, PC_out<=fetch_addr, instr_valid<=1, fetch_count+=1 (wrapping 16'hFFFF->0), state<=ADVANCE.
REQ-009 SHALL, in FETCH with imem_req=1 and imem_ack=0, increment the 8-bit wait_cnt.
REQ-010 SHALL, when wait_cnt would reach 255, set fetch_err=1 and enter ERROR.
REQ-011 SHALL clear wait_cnt on every capture and hold it while stalled.
REQ-012 SHALL, in ADVANCE, load fetch_addr<=PC_next (already updated by the intervening negedge), clear instr_valid to 0 with instr_out<=NOP_INSTR, and set state<=FETCH; throughput is therefore one instruction per 2 cycles minimum.
REQ-013 SHALL, when stalled (|stall=1) in FETCH, issue no request and leave instr_out, instr_valid, PC_out and fetch_addr unchanged.
REQ-014 SHALL, when stalled in ADVANCE, still perform the ADVANCE update.
REQ-015 SHALL give flush priority over capture, stall and ADVANCE: fetch_addr<={flush_pc[15:1],1'b0}, instr_out<=NOP_INSTR, instr_valid<=0, wait_cnt<=0, state<=FETCH.
REQ-016 SHALL discard any imem_ack arriving in a flush cycle, and SHALL NOT increment fetch_count on it.
REQ-017 SHALL leave ERROR only via flush or rst; fetch_err is cleared only by rst.
REQ-018 SHALL drive three_msb and thirteen_lsb combinationally from instr_out.
REQ-019 SHALL handle address wrap-around: fetch_addr is 16-bit, and PC_next=16'h0000 after 16'hFFFE is accepted without special handling.

Reset
REQ-020 SHALL, on rst=1, immediately set state=FETCH, fetch_addr=RESET_PC, instr_out=NOP_INSTR, instr_valid=0, PC_out=RESET_PC, wait_cnt=0, fetch_count=0 and fetch_err=0.
REQ-021 SHALL drop imem_req in the same cycle when rst asserts mid-request, and SHALL ignore any ack that follows.
REQ-022 SHALL issue its first request in the first cycle after rst deasserts.

Verification
REQ-023 SHALL cover zero-wait fetch: with rst released, ack=1 every request and rdata=16'h6123 -> capture at cycle 1, PC_out=16'h0000, instr_valid=1, then imem_addr=PC_next in cycle 3.
REQ-024 SHALL cover the wait/stall interaction: with ack delayed 3 cycles and stall=8'h04 asserted for 2 cycles mid-wait -> wait_cnt reaches 3, not 5, imem_req=0 while stalled, and instr_out unchanged.
REQ-025 SHALL cover simultaneous flush and ack: flush=1, flush_pc=16'h0101 and ack=1 in the same cycle -> rdata discarded, fetch_count unchanged, next imem_addr=16'h0100.
REQ-026 SHALL cover timeout: ack held 0 for 255 request cycles -> fetch_err=1 and state ERROR; a subsequent flush resumes fetching while fetch_err stays 1.
REQ-027 SHALL cover wrap-around: with fetch_count=16'hFFFF, one capture -> fetch_count=0; PC_next=16'h0000 following PC_out=16'hFFFE -> imem_addr=16'h0000.
REQ-028 SHALL cover reset mid-request: rst pulsed while imem_req=1 -> all outputs at reset values the same cycle, and a late ack is ignored.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues imem reads, captures into the IF/ID register, tracks timeouts.
// Latency: capture on the cycle imem_ack arrives; next fetch issues two cycles after a capture.
// Backpressure: any stall bit suppresses requests in FETCH; flush overrides everything.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h4C00  // bits [15:13] must not be 3'b000 or 3'b001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  stall,
  input  logic [15:0] PC_next,
  input  logic        flush,
  input  logic [15:0] flush_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  output logic [15:0] PC_out,
  output logic [2:0]  three_msb,
  output logic [12:0] thirteen_lsb,
  output logic        fetch_err,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    ADVANCE = 2'd1,
    ERROR   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] fetch_addr_q, fetch_addr_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic        err_q, err_d;

  // Request only in FETCH when neither stalled nor flushed; rst gates it so a
  // request drops in the very cycle reset asserts.
  always_comb begin
    imem_req  = (state_q == FETCH) & ~(|stall) & ~flush & ~rst;
    imem_addr = {fetch_addr_q[15:1], 1'b0};
  end

  // Output views of the IF/ID register and status.
  always_comb begin
    instr_out    = instr_q;
    instr_valid  = valid_q;
    PC_out       = pc_q;
    three_msb    = instr_q[15:13];
    thirteen_lsb = instr_q[12:0];
    fetch_err    = err_q;
    fetch_count  = fetch_count_q;
  end

  // Next-state logic: flush first, then per-state behaviour.
  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    instr_d       = instr_q;
    valid_d       = valid_q;
    pc_d          = pc_q;
    wait_cnt_d    = wait_cnt_q;
    fetch_count_d = fetch_count_q;
    err_d         = err_q;

    if (flush) begin
      // Any ack in this cycle is dropped; the restart address is halfword aligned.
      fetch_addr_d = {flush_pc[15:1], 1'b0};
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      wait_cnt_d   = 8'd0;
      state_d      = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_req) begin
            if (imem_ack) begin
              instr_d       = imem_rdata;
              pc_d          = fetch_addr_q;
              valid_d       = 1'b1;
              fetch_count_d = fetch_count_q + 16'd1;
              wait_cnt_d    = 8'd0;
              state_d       = ADVANCE;
            end else if (wait_cnt_q == 8'd254) begin
              // The 255th unanswered request cycle is a timeout.
              wait_cnt_d = 8'd255;
              err_d      = 1'b1;
              state_d    = ERROR;
            end else begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end
        end
        ADVANCE: begin
          // PC_next was refreshed by the controller on the preceding negedge;
          // this happens regardless of stall.
          fetch_addr_d = PC_next;
          instr_d      = NOP_INSTR;
          valid_d      = 1'b0;
          state_d      = FETCH;
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      fetch_addr_q  <= RESET_PC;
      instr_q       <= NOP_INSTR;
      valid_q       <= 1'b0;
      pc_q          <= RESET_PC;
      wait_cnt_q    <= 8'd0;
      fetch_count_q <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      wait_cnt_q    <= wait_cnt_d;
      fetch_count_q <= fetch_count_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, zero-wait, wait/stall, flush, timeout, wrap, reset mid-request.
// Inputs change 1 ns after posedge; outputs are sampled there, away from the active edge.
// Every wait is a fixed cycle count; a global time limit guards against hangs.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [7:0]  stall;
  logic [15:0] PC_next;
  logic        flush;
  logic [15:0] flush_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [15:0] PC_out;
  logic [2:0]  three_msb;
  logic [12:0] thirteen_lsb;
  logic        fetch_err;
  logic [15:0] fetch_count;

  int vectors;
  int miscompares;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .PC_next      (PC_next),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .PC_out       (PC_out),
    .three_msb    (three_msb),
    .thirteen_lsb (thirteen_lsb),
    .fetch_err    (fetch_err),
    .fetch_count  (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 8'h00; PC_next = 16'h0000; flush = 1'b0;
    flush_pc = 16'h0000; imem_ack = 1'b0; imem_rdata = 16'h0000;
    #1;
    vectors++; if (instr_out !== 16'h4C00) begin miscompares++; $display("FAIL rst_instr got %h want %h", instr_out, 16'h4C00); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    vectors++; if (PC_out !== 16'h0000) begin miscompares++; $display("FAIL rst_pc got %h want 0000", PC_out); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", imem_req); end
    vectors++; if (fetch_count !== 16'h0000) begin miscompares++; $display("FAIL rst_count got %h want 0000", fetch_count); end
    vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", fetch_err); end
    vectors++; if (three_msb !== 3'b010 || thirteen_lsb !== 13'h0C00) begin miscompares++; $display("FAIL rst_fields got %b/%h want 010/0c00", three_msb, thirteen_lsb); end
    cyc();
    rst = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_first_req got %b@%h want 1@0000", imem_req, imem_addr); end
  endtask

  task automatic test_zero_wait();
    imem_ack = 1'b1; imem_rdata = 16'h6123; PC_next = 16'h0002;
    cyc();  // capture
    vectors++; if (instr_out !== 16'h6123 || instr_valid !== 1'b1) begin miscompares++; $display("FAIL zw_capture got %h/%b want 6123/1", instr_out, instr_valid); end
    vectors++; if (PC_out !== 16'h0000 || fetch_count !== 16'd1) begin miscompares++; $display("FAIL zw_pc_count got %h/%h want 0000/0001", PC_out, fetch_count); end
    vectors++; if (three_msb !== 3'b011 || thirteen_lsb !== 13'h0123) begin miscompares++; $display("FAIL zw_fields got %b/%h want 011/0123", three_msb, thirteen_lsb); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL zw_req_in_advance got %b want 0", imem_req); end
    imem_rdata = 16'h7ABC;
    cyc();  // advance
    vectors++; if (instr_valid !== 1'b0 || instr_out !== 16'h4C00) begin miscompares++; $display("FAIL zw_bubble got %h/%b want 4c00/0", instr_out, instr_valid); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin miscompares++; $display("FAIL zw_next_addr got %b@%h want 1@0002", imem_req, imem_addr); end
    PC_next = 16'h0004;
    cyc();  // back-to-back capture at 0002
    vectors++; if (instr_out !== 16'h7ABC || PC_out !== 16'h0002 || fetch_count !== 16'd2) begin miscompares++; $display("FAIL zw_second got %h/%h/%h want 7abc/0002/0002", instr_out, PC_out, fetch_count); end
    imem_ack = 1'b0;
    cyc();  // advance to 0004
    vectors++; if (imem_addr !== 16'h0004) begin miscompares++; $display("FAIL zw_addr3 got %h want 0004", imem_addr); end
  endtask

  task automatic test_wait_stall();
    imem_ack = 1'b0;
    cyc(); cyc();  // two unanswered requests
    vectors++; if (dut.wait_cnt_q !== 8'd2) begin miscompares++; $display("FAIL ws_wait2 got %0d want 2", dut.wait_cnt_q); end
    stall = 8'h04;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL ws_req_stalled got %b want 0", imem_req); end
    cyc(); cyc();
    vectors++; if (dut.wait_cnt_q !== 8'd2) begin miscompares++; $display("FAIL ws_wait_held got %0d want 2", dut.wait_cnt_q); end
    vectors++; if (instr_out !== 16'h4C00 || instr_valid !== 1'b0 || PC_out !== 16'h0002 || imem_addr !== 16'h0004) begin miscompares++; $display("FAIL ws_held got %h/%b/%h/%h want 4c00/0/0002/0004", instr_out, instr_valid, PC_out, imem_addr); end
    stall = 8'h00;
    cyc();
    vectors++; if (dut.wait_cnt_q !== 8'd3) begin miscompares++; $display("FAIL ws_wait3 got %0d want 3", dut.wait_cnt_q); end
    imem_ack = 1'b1; imem_rdata = 16'h1111; PC_next = 16'h0006;
    cyc();  // capture
    vectors++; if (instr_out !== 16'h1111 || PC_out !== 16'h0004 || fetch_count !== 16'd3 || dut.wait_cnt_q !== 8'd0) begin miscompares++; $display("FAIL ws_capture got %h/%h/%h/%0d want 1111/0004/0003/0", instr_out, PC_out, fetch_count, dut.wait_cnt_q); end
    imem_ack = 1'b0; stall = 8'h80;
    cyc();  // stalled advance still advances
    vectors++; if (instr_valid !== 1'b0 || imem_addr !== 16'h0006 || imem_req !== 1'b0) begin miscompares++; $display("FAIL ws_stalled_adv got %b/%h/%b want 0/0006/0", instr_valid, imem_addr, imem_req); end
    stall = 8'h00;
  endtask

  task automatic test_flush_ack();
    flush = 1'b1; flush_pc = 16'h0101; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL fl_req got %b want 0", imem_req); end
    cyc();
    vectors++; if (fetch_count !== 16'd3 || instr_out !== 16'h4C00 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL fl_discard got %h/%h/%b want 0003/4c00/0", fetch_count, instr_out, instr_valid); end
    flush = 1'b0; imem_ack = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || PC_out !== 16'h0004) begin miscompares++; $display("FAIL fl_restart got %b@%h pc %h want 1@0100 pc 0004", imem_req, imem_addr, PC_out); end
  endtask

  task automatic test_timeout();
    imem_ack = 1'b0;
    for (int i = 0; i < 254; i++) cyc();
    vectors++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin miscompares++; $display("FAIL to_before got err %b req %b want 0/1", fetch_err, imem_req); end
    cyc();
    vectors++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL to_error got err %b req %b want 1/0", fetch_err, imem_req); end
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    cyc();  // stray ack in ERROR
    vectors++; if (fetch_count !== 16'd3 || imem_req !== 1'b0) begin miscompares++; $display("FAIL to_stuck got count %h req %b want 0003/0", fetch_count, imem_req); end
    imem_ack = 1'b0; flush = 1'b1; flush_pc = 16'h0200;
    cyc();
    flush = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200 || fetch_err !== 1'b1) begin miscompares++; $display("FAIL to_resume got %b@%h err %b want 1@0200 err 1", imem_req, imem_addr, fetch_err); end
    imem_ack = 1'b1; imem_rdata = 16'h2222; PC_next = 16'hFFFE;
    cyc();
    vectors++; if (fetch_count !== 16'd4 || PC_out !== 16'h0200 || fetch_err !== 1'b1) begin miscompares++; $display("FAIL to_capture got %h/%h err %b want 0004/0200 err 1", fetch_count, PC_out, fetch_err); end
    imem_ack = 1'b0;
    cyc();  // advance to FFFE
  endtask

  task automatic test_wrap();
    vectors++; if (imem_addr !== 16'hFFFE) begin miscompares++; $display("FAIL wr_addr got %h want fffe", imem_addr); end
    dut.fetch_count_q = 16'hFFFF;
    imem_ack = 1'b1; imem_rdata = 16'h3333; PC_next = 16'h0000;
    cyc();
    vectors++; if (fetch_count !== 16'h0000 || PC_out !== 16'hFFFE) begin miscompares++; $display("FAIL wr_count got %h pc %h want 0000 pc fffe", fetch_count, PC_out); end
    imem_ack = 1'b0;
    cyc();
    vectors++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin miscompares++; $display("FAIL wr_pc got %b@%h want 1@0000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    PC_next = 16'h0040;
    cyc();  // request pending, no ack
    rst = 1'b1;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rm_req got %b want 0", imem_req); end
    vectors++; if (instr_out !== 16'h4C00 || PC_out !== 16'h0000 || fetch_err !== 1'b0 || fetch_count !== 16'h0000 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL rm_state got %h/%h/%b/%h/%b want 4c00/0000/0/0000/0", instr_out, PC_out, fetch_err, fetch_count, instr_valid); end
    imem_ack = 1'b1; imem_rdata = 16'h9999;
    cyc();
    vectors++; if (fetch_count !== 16'h0000 || instr_out !== 16'h4C00) begin miscompares++; $display("FAIL rm_late_ack got %h/%h want 0000/4c00", fetch_count, instr_out); end
    imem_ack = 1'b0; rst = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin miscompares++; $display("FAIL rm_restart got %b@%h want 1@0000", imem_req, imem_addr); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_zero_wait();
    test_wait_stall();
    test_flush_ack();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
